// File: rtl/onectr_progmem.sv
// Program memory and load controller for the one-counter datapath.
// Streams a program in, then decodes the word at PCAddress combinationally.
module onectr_progmem #(
    parameter int PCSIZE = 8,
    parameter int IWIDTH = 30 + PCSIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req_i,
    input  logic              prog_valid_i,
    output logic              prog_ready_o,
    input  logic [IWIDTH-1:0] prog_data_i,
    input  logic              prog_last_i,
    output logic              run_o,
    output logic              halted_o,
    output logic [PCSIZE:0]   prog_len_o,
    input  logic [PCSIZE-1:0] PCAddress,
    output logic [7:0]        Ctrl,
    output logic [3:0]        Sel,
    output logic              Wen,
    output logic [3:0]        WA,
    output logic [3:0]        RAA,
    output logic [3:0]        RAB,
    output logic [2:0]        Op,
    output logic              JP,
    output logic              JF,
    output logic [PCSIZE-1:0] JumpAddress
);

    localparam int DEPTH = 1 << PCSIZE;
    localparam logic [PCSIZE:0] LAST_ADDR = (PCSIZE+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PCSIZE:0]   len_q, len_d;
    logic              accept;
    logic [PCSIZE-1:0] wptr;
    logic [IWIDTH-1:0] mem_q [DEPTH];
    logic [IWIDTH-1:0] word;

    // The write pointer always equals the number of words loaded so far.
    assign wptr   = len_q[PCSIZE-1:0];
    assign accept = (state_q == S_LOAD) && prog_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (load_req_i) begin
                    state_d = S_LOAD;
                    len_d   = '0;
                end
            end
            S_LOAD: begin
                if (prog_valid_i) begin
                    len_d = len_q + 1'b1;
                    // Filling the last address ends the load; never wrap onto word 0.
                    if (prog_last_i || (len_q == LAST_ADDR)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (load_req_i) begin
                    state_d = S_LOAD;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                len_d   = '0;
            end
        endcase
    end

    // Contents are not reset; words past prog_len are masked on the read side.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem_q[wptr] <= prog_data_i;
        end
    end

    assign word         = mem_q[PCAddress];
    assign prog_ready_o = (state_q == S_LOAD);
    assign run_o        = (state_q == S_RUN);
    assign halted_o     = run_o && ({1'b0, PCAddress} >= len_q);
    assign prog_len_o   = len_q;

    always_comb begin
        Ctrl        = '0;
        Sel         = '0;
        Wen         = 1'b0;
        WA          = '0;
        RAA         = '0;
        RAB         = '0;
        Op          = '0;
        JP          = 1'b0;
        JF          = 1'b0;
        JumpAddress = '0;
        if (halted_o) begin
            // Past the end of the program: spin in place with no side effects.
            JP          = 1'b1;
            JumpAddress = PCAddress;
        end else if (run_o) begin
            Ctrl        = word[IWIDTH-1 -: 8];
            Sel         = word[IWIDTH-9 -: 4];
            Wen         = word[IWIDTH-13];
            WA          = word[IWIDTH-14 -: 4];
            RAA         = word[IWIDTH-18 -: 4];
            RAB         = word[IWIDTH-22 -: 4];
            Op          = word[IWIDTH-26 -: 3];
            JP          = word[PCSIZE+1];
            JF          = word[PCSIZE];
            JumpAddress = word[PCSIZE-1:0];
        end
    end

endmodule

// File: tb/tb_onectr_progmem.sv
// Randomized and directed bench for onectr_progmem against a behavioural model.
module tb_onectr_progmem;

    localparam int PCS = 4;
    localparam int IW  = 30 + PCS;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req_i, prog_valid_i, prog_last_i;
    logic          prog_ready_o, run_o, halted_o;
    logic [IW-1:0] prog_data_i;
    logic [PCS:0]  prog_len_o;
    logic [PCS-1:0] PCAddress;
    logic [7:0]    Ctrl;
    logic [3:0]    Sel, WA, RAA, RAB;
    logic          Wen, JP, JF;
    logic [2:0]    Op;
    logic [PCS-1:0] JumpAddress;

    onectr_progmem #(.PCSIZE(PCS)) dut (
        .clk(clk), .rst(rst), .load_req_i(load_req_i), .prog_valid_i(prog_valid_i),
        .prog_ready_o(prog_ready_o), .prog_data_i(prog_data_i), .prog_last_i(prog_last_i),
        .run_o(run_o), .halted_o(halted_o), .prog_len_o(prog_len_o), .PCAddress(PCAddress),
        .Ctrl(Ctrl), .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op),
        .JP(JP), .JF(JF), .JumpAddress(JumpAddress)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 0;

    // Model: mode 0 = idle, 1 = loading, 2 = running.
    int            m_mode = 0;
    int            m_len = 0;
    logic [IW-1:0] m_mem [DEP];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_len  = 0;
        end else if (m_mode == 0) begin
            if (load_req_i) begin m_mode = 1; m_len = 0; end
        end else if (m_mode == 1) begin
            if (prog_valid_i) begin
                m_mem[m_len] = prog_data_i;
                m_len++;
                if (prog_last_i || m_len == DEP) m_mode = 2;
            end
        end else begin
            if (load_req_i) begin m_mode = 1; m_len = 0; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [IW-1:0] w;
            logic [63:0]   ew;
            bit            hlt;
            hlt = (m_mode == 2) && (int'(PCAddress) >= m_len);
            w   = '0;
            if (m_mode == 2 && !hlt) w = m_mem[PCAddress];
            ew  = 64'(w);
            if (hlt) ew = (64'd1 << 5) | 64'(PCAddress);
            chk("ready", prog_ready_o, m_mode == 1);
            chk("run", run_o, m_mode == 2);
            chk("halted", halted_o, hlt);
            chk("prog_len", prog_len_o, m_len);
            chk("Ctrl", Ctrl, (ew >> 26) & 8'hFF);
            chk("Sel", Sel, (ew >> 22) & 4'hF);
            chk("Wen", Wen, (ew >> 21) & 1);
            chk("WA", WA, (ew >> 17) & 4'hF);
            chk("RAA", RAA, (ew >> 13) & 4'hF);
            chk("RAB", RAB, (ew >> 9) & 4'hF);
            chk("Op", Op, (ew >> 6) & 3'h7);
            chk("JP", JP, (ew >> 5) & 1);
            chk("JF", JF, (ew >> 4) & 1);
            chk("JumpAddress", JumpAddress, ew & 4'hF);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        load_req_i = 0; prog_valid_i = 0; prog_last_i = 0;
    endtask

    task automatic send(input logic [IW-1:0] d, input logic last);
        prog_valid_i = 1; prog_data_i = d; prog_last_i = last;
        step();
        prog_valid_i = 0; prog_last_i = 0;
    endtask

    task automatic start_load();
        load_req_i = 1; step(); load_req_i = 0;
    endtask

    logic [IW-1:0] w1;
    logic [63:0]   rnd;

    initial begin
        w1 = {8'hA5, 4'h3, 1'b1, 4'h7, 4'h2, 4'h9, 3'h5, 1'b0, 1'b1, 4'hC};
        rst = 1; idle_in(); prog_data_i = '0; PCAddress = '0;
        step(); step();
        chk_en = 1;
        @(negedge clk);
        chk("rst_len", prog_len_o, 0);
        chk("rst_run", run_o, 0);
        chk("rst_ready", prog_ready_o, 0);
        #1; rst = 0;

        // 3-word program, decode of word 1.
        start_load();
        send(34'h0_1111_1111, 0);
        send(w1, 0);
        send(34'h3_3333_3333, 1);
        PCAddress = 1;
        @(negedge clk);
        chk("lit_len3", prog_len_o, 3);
        chk("lit_run", run_o, 1);
        chk("lit_ctrl", Ctrl, 8'hA5);
        chk("lit_wa", WA, 4'h7);
        chk("lit_op", Op, 3'h5);
        chk("lit_jf", JF, 1);
        chk("lit_ja", JumpAddress, 4'hC);
        PCAddress = 5;
        @(negedge clk);
        chk("lit_halt", halted_o, 1);
        chk("lit_halt_wen", Wen, 0);
        chk("lit_halt_jp", JP, 1);
        chk("lit_halt_ja", JumpAddress, 5);

        // Reload from RUN, then a 1-word program.
        start_load();
        @(negedge clk);
        chk("reload_run", run_o, 0);
        chk("reload_ready", prog_ready_o, 1);
        chk("reload_ctrl", Ctrl, 0);
        send(w1, 1);
        PCAddress = 1;
        @(negedge clk);
        chk("one_halt", halted_o, 1);

        // Valid gap, last on second valid.
        start_load();
        send(34'h2_AAAA_5555, 0);
        step();
        send(34'h1_5555_AAAA, 1);
        @(negedge clk);
        chk("gap_len", prog_len_o, 2);

        // Full 16-word stream without last.
        start_load();
        for (int i = 0; i < DEP; i++) send(IW'(i * 3 + 1), 0);
        prog_valid_i = 1; prog_data_i = '1;
        @(negedge clk);
        chk("full_len", prog_len_o, 16);
        chk("full_ready", prog_ready_o, 0);
        chk("full_run", run_o, 1);
        step(); prog_valid_i = 0;
        PCAddress = 0;
        @(negedge clk);
        chk("full_w0", JumpAddress, 4'h1);

        // Reset mid-load, then reload 4 words.
        start_load();
        send(34'h0_0000_0001, 0);
        send(34'h0_0000_0002, 0);
        rst = 1; step(); rst = 0;
        @(negedge clk);
        chk("mid_rst_len", prog_len_o, 0);
        chk("mid_rst_ready", prog_ready_o, 0);
        start_load();
        for (int i = 0; i < 3; i++) send(IW'(i), 0);
        send(w1, 1);
        PCAddress = 3;
        @(negedge clk);
        chk("rel_ctrl", Ctrl, 8'hA5);
        chk("rel_ja", JumpAddress, 4'hC);

        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom % 300) == 0;
            load_req_i   = ($urandom % 25) == 0;
            prog_valid_i = $urandom % 2;
            prog_last_i  = ($urandom % 7) == 0;
            rnd          = {$urandom, $urandom};
            prog_data_i  = rnd[IW-1:0];
            PCAddress    = PCS'($urandom % DEP);
            step();
        end
        idle_in();
        step();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
